mem_copy_dma: RTL and testbench
===============================

# mem_copy_dma

Single-channel DMA engine that acts as the initiator on one port of the dual-port byte-enabled synchronous-read block RAM. It copies a block of words from a source address to a destination address, or fills a block with a constant. It sits beside the CPU data path: the CPU keeps the other RAM port, and this block owns the second port exclusively. Overlapping copies have memmove semantics.

## Interface
- DWIDTH, 32, data word width; must be a multiple of 8
- AWIDTH, 14, word address width
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill; captured with start
- src_addr  in  AWIDTH  source word address; captured with start; ignored in fill mode
- dst_addr  in  AWIDTH  destination word address; captured with start
- len  in  AWIDTH+1  word count; 0 is legal
- fill_value  in  DWIDTH  fill pattern; captured with start
- abort  in  1  cancel the operation in progress
- busy  out  1  high while an operation is active
- done  out  1  one-cycle pulse on normal completion
- mem_en  out  1  RAM port enable
- mem_wbe  out  DWIDTH/8  RAM write byte enables
- mem_addr  out  AWIDTH  RAM address
- mem_d  out  DWIDTH  RAM write data
- mem_q  in  DWIDTH  RAM read data; valid the cycle after a read enable

## Operation
- FSM states: IDLE, RD, WR, FILL, FIN.
- **IDLE**
  - start with len=0 → FIN; no RAM access.
  - start with mode=0 → RD.
  - start with mode=1 → FILL.
  - All command inputs are captured into registers on the start edge.
- **Direction:** descending when mode=0, dst>src and dst<src+len (unsigned, unwrapped compare). Otherwise ascending.
  - Ascending: word i uses addresses base+i.
  - Descending: word i uses addresses base+len-1-i.
  - Address arithmetic wraps modulo 2^AWIDTH.
- **RD:** mem_en=1, mem_wbe=0, mem_addr=current source address → WR.
- **WR:** mem_en=1, mem_wbe=all ones, mem_addr=current destination address, mem_d=mem_q (passed through combinationally).
  - Decrement the remaining count.
  - Remaining becomes 0 → FIN; otherwise → RD.
- **FILL:** mem_en=1, mem_wbe=all ones, mem_d=fill_value, one word per cycle.
  - Remaining becomes 0 → FIN.
- **FIN:** done=1, busy=0, no RAM access → IDLE.
- **abort:** in RD, WR or FILL, the cycle in which abort is high issues no RAM access (mem_en=0). Next state is IDLE with no done pulse. Words already written remain written.
- start is ignored outside IDLE. abort is ignored in IDLE and FIN.
- RST in any state → IDLE. All outputs and internal registers are cleared.
- When mem_en=0: mem_wbe=0, mem_addr=0, mem_d=0.

## Timing
- Reset values: busy=0, done=0, mem_en=0, mem_wbe=0, mem_addr=0, mem_d=0.
- Cycle 0 is the cycle in which start is sampled high. Operation begins in cycle 1.
- Copy of N≥1 words:
  - Reads in cycles 1,3,…,2N-1; writes in cycles 2,4,…,2N.
  - done in cycle 2N+1; busy high in cycles 1..2N.
- Fill of N≥1 words: writes in cycles 1..N; done in cycle N+1; busy high in cycles 1..N.
- len=0: done in cycle 1; busy never rises.
- A new start is accepted in the cycle after done, at the earliest.
- mem_* outputs are combinational from the state and address/count registers. RAM read latency is exactly one cycle.

## Structure
- Package mem_copy_dma_pkg holds:
  - state encoding (IDLE, RD, WR, FILL, FIN)
  - mode constants MODE_COPY=0, MODE_FILL=1
- One sub-module, mem_copy_addr_gen:
  - holds the source/destination address registers, the remaining-count register and the direction flag
  - performs the overlap compare
  - exposes cur_src, cur_dst, last and step inputs
- The top level contains the FSM and the RAM port muxing only.

## Test plan
- Copy, src=0x010, dst=0x100, len=4, RAM[0x10..0x13]=A,B,C,D → reads at 0x10,0x11,0x12,0x13 in cycles 1,3,5,7; writes at 0x100..0x103 in cycles 2,4,6,8; done in cycle 9; RAM[0x100..0x103]=A,B,C,D.
- Overlap, src=0x20, dst=0x22, len=4, RAM[0x20..0x23]=1,2,3,4 → descending order (first read 0x23, first write 0x25); RAM[0x22..0x25]=1,2,3,4.
- Fill, dst=0x3FFE, len=4, fill_value=0xDEADBEEF (AWIDTH=14) → writes at 0x3FFE, 0x3FFF, 0x0000, 0x0001 in cycles 1..4; done in cycle 5.
- len=0 → done in cycle 1; mem_en never high; busy stays 0.
- abort in cycle 4 of a copy with len=8 → mem_en=0 in cycle 4; IDLE in cycle 5; no done pulse; only the write at dst+0 has occurred.
- RST in cycle 3 of a fill; start high while busy → all outputs 0 the cycle after reset; the start issued while busy is ignored, with no change to len or addresses.

Source files
------------

// File: rtl/mem_copy_dma_pkg.sv
// mem_copy_dma_pkg
//   Shared definitions for the mem_copy_dma block:
//   - state_t   : FSM state encoding (IDLE, RD, WR, FILL, FIN)
//   - MODE_COPY : command mode value for a block copy
//   - MODE_FILL : command mode value for a constant fill
package mem_copy_dma_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    FILL = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// mem_copy_addr_gen
//   Address and count bookkeeping for mem_copy_dma. On load it decides the
//   copy direction (descending when the destination overlaps the upper part
//   of the source range, giving memmove behaviour) and presets the source and
//   destination pointers to the first word to be moved. Each step advances
//   both pointers one word in the chosen direction and decrements the
//   remaining word count. Addresses wrap modulo 2^AWIDTH.
//
// Ports
//   CLK, RST  : clock, synchronous active-high reset
//   load      : capture a new command (src_addr, dst_addr, len, mode)
//   mode      : MODE_COPY / MODE_FILL; only copies may run descending
//   src_addr  : source word address of the block
//   dst_addr  : destination word address of the block
//   len       : word count
//   step      : one word has been moved; advance pointers and count
//   cur_src   : current source word address
//   cur_dst   : current destination word address
//   last      : the current word is the final one of the block
module mem_copy_addr_gen
  import mem_copy_dma_pkg::*;
#(
  parameter int AWIDTH = 14
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              mode,
  input  logic [AWIDTH-1:0] src_addr,
  input  logic [AWIDTH-1:0] dst_addr,
  input  logic [AWIDTH:0]   len,
  input  logic              step,
  output logic [AWIDTH-1:0] cur_src,
  output logic [AWIDTH-1:0] cur_dst,
  output logic              last
);

  localparam logic [AWIDTH-1:0] ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH:0]   CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};

  logic [AWIDTH-1:0] src_reg;
  logic [AWIDTH-1:0] dst_reg;
  logic [AWIDTH:0]   remaining;
  logic              descending;

  logic [AWIDTH+1:0] src_end;
  logic              overlap;
  logic [AWIDTH-1:0] len_m1;

  // The overlap test uses unwrapped arithmetic (two extra bits) so that a
  // source range running past the top of memory is judged on true magnitude.
  assign src_end = {2'b00, src_addr} + {1'b0, len};
  assign overlap = (mode == MODE_COPY) &&
                   (dst_addr > src_addr) &&
                   ({2'b00, dst_addr} < src_end);
  assign len_m1  = len[AWIDTH-1:0] - ADDR_ONE;

  // Descending transfers start at base+len-1; the truncated add wraps
  // naturally modulo 2^AWIDTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      src_reg    <= '0;
      dst_reg    <= '0;
      remaining  <= '0;
      descending <= 1'b0;
    end else if (load) begin
      src_reg    <= overlap ? (src_addr + len_m1) : src_addr;
      dst_reg    <= overlap ? (dst_addr + len_m1) : dst_addr;
      remaining  <= len;
      descending <= overlap;
    end else if (step) begin
      src_reg   <= descending ? (src_reg - ADDR_ONE) : (src_reg + ADDR_ONE);
      dst_reg   <= descending ? (dst_reg - ADDR_ONE) : (dst_reg + ADDR_ONE);
      remaining <= remaining - CNT_ONE;
    end
  end

  assign cur_src = src_reg;
  assign cur_dst = dst_reg;
  assign last    = (remaining == CNT_ONE);

endmodule

// File: rtl/mem_copy_dma.sv
// mem_copy_dma
//   Single-channel DMA engine owning one port of a dual-port synchronous-read
//   block RAM. Copies a block of words (memmove semantics for overlapping
//   ranges) or fills a block with a constant. A copy alternates read and
//   write cycles; the read data arrives one cycle later and is passed straight
//   through to the write data. A fill writes one word per cycle.
//
// Ports
//   CLK, RST   : clock, synchronous active-high reset
//   start      : command strobe, honoured only in IDLE
//   mode       : 0 = copy, 1 = fill
//   src_addr   : source word address (copy only)
//   dst_addr   : destination word address
//   len        : word count, 0 completes immediately
//   fill_value : fill pattern
//   abort      : cancel the running operation, no done pulse
//   busy       : operation in progress
//   done       : one-cycle pulse on normal completion
//   mem_en     : RAM port enable
//   mem_wbe    : RAM byte write enables (all zero = read)
//   mem_addr   : RAM word address
//   mem_d      : RAM write data
//   mem_q      : RAM read data, valid the cycle after a read
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 14
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                mode,
  input  logic [AWIDTH-1:0]   src_addr,
  input  logic [AWIDTH-1:0]   dst_addr,
  input  logic [AWIDTH:0]     len,
  input  logic [DWIDTH-1:0]   fill_value,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                mem_en,
  output logic [DWIDTH/8-1:0] mem_wbe,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_d,
  input  logic [DWIDTH-1:0]   mem_q
);

  state_t            state;
  logic [DWIDTH-1:0] fill_reg;

  logic              load;
  logic              step;
  logic [AWIDTH-1:0] cur_src;
  logic [AWIDTH-1:0] cur_dst;
  logic              last;

  // A word is consumed on every unaborted write cycle, copy or fill.
  assign load = (state == IDLE) && start;
  assign step = ((state == WR) || (state == FILL)) && !abort;

  mem_copy_addr_gen #(
    .AWIDTH (AWIDTH)
  ) u_addr_gen (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .step     (step),
    .cur_src  (cur_src),
    .cur_dst  (cur_dst),
    .last     (last)
  );

  // Control FSM; busy and done are registered alongside the state so they
  // line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      fill_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            fill_reg <= fill_value;
            if (len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (mode == MODE_COPY) begin
              state <= RD;
              busy  <= 1'b1;
            end else begin
              state <= FILL;
              busy  <= 1'b1;
            end
          end
        end
        RD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WR;
          end
        end
        WR, FILL: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (state == WR) begin
            state <= RD;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // RAM port mux. An abort cycle issues no access, and every field is held
  // at zero whenever the port is idle.
  always_comb begin
    mem_en   = 1'b0;
    mem_wbe  = '0;
    mem_addr = '0;
    mem_d    = '0;
    case (state)
      RD: begin
        if (!abort) begin
          mem_en   = 1'b1;
          mem_addr = cur_src;
        end
      end
      WR: begin
        if (!abort) begin
          mem_en   = 1'b1;
          mem_wbe  = '1;
          mem_addr = cur_dst;
          mem_d    = mem_q;
        end
      end
      FILL: begin
        if (!abort) begin
          mem_en   = 1'b1;
          mem_wbe  = '1;
          mem_addr = cur_dst;
          mem_d    = fill_reg;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma
//   Directed self-checking bench for mem_copy_dma with a behavioural
//   synchronous-read byte-enabled RAM on the DMA port.
module tb_mem_copy_dma;
  import mem_copy_dma_pkg::*;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 14;
  localparam int BW     = DWIDTH / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [AWIDTH-1:0] src_addr = '0;
  logic [AWIDTH-1:0] dst_addr = '0;
  logic [AWIDTH:0]   len = '0;
  logic [DWIDTH-1:0] fill_value = '0;
  logic              abort = 1'b0;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic [BW-1:0]     mem_wbe;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_d;
  logic [DWIDTH-1:0] mem_q = '0;

  logic [DWIDTH-1:0] ram [0:(1<<AWIDTH)-1];
  logic              poke_en = 1'b0;
  logic [AWIDTH-1:0] poke_addr = '0;
  logic [DWIDTH-1:0] poke_data = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_copy_dma #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_value (fill_value),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .mem_en     (mem_en),
    .mem_wbe    (mem_wbe),
    .mem_addr   (mem_addr),
    .mem_d      (mem_d),
    .mem_q      (mem_q)
  );

  // RAM model: one-cycle read latency, byte-enabled writes, plus a bench
  // back door used only while the DMA is idle.
  always @(posedge clk) begin
    if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (mem_en) begin
      if (mem_wbe == '0) begin
        mem_q <= ram[mem_addr];
      end else begin
        for (int b = 0; b < BW; b++) begin
          if (mem_wbe[b]) ram[mem_addr][8*b +: 8] <= mem_d[8*b +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    tick();
    poke_en   = 1'b0;
  endtask

  // Drives a command for one cycle (cycle 0); returns sampling cycle 1.
  task automatic drive_start(input logic m, input logic [AWIDTH-1:0] s,
                             input logic [AWIDTH-1:0] d, input logic [AWIDTH:0] n,
                             input logic [DWIDTH-1:0] f);
    mode       = m;
    src_addr   = s;
    dst_addr   = d;
    len        = n;
    fill_value = f;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy, done, mem_en, mem_wbe, mem_addr, mem_d} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b en=%b wbe=%h addr=%h d=%h, want all 0",
               busy, done, mem_en, mem_wbe, mem_addr, mem_d);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_copy();
    logic [DWIDTH-1:0] data [4] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
    logic [AWIDTH-1:0] rd_a [4] = '{14'h010, 14'h011, 14'h012, 14'h013};
    logic [AWIDTH-1:0] wr_a [4] = '{14'h100, 14'h101, 14'h102, 14'h103};
    logic eb, ed, ee;
    logic [BW-1:0] ew;
    logic [AWIDTH-1:0] ea;
    logic [DWIDTH-1:0] edat;
    for (int i = 0; i < 4; i++) begin
      poke(rd_a[i], data[i]);
      poke(wr_a[i], '0);
    end
    drive_start(MODE_COPY, 14'h010, 14'h100, 15'd4, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      eb = 1'b0; ed = 1'b0; ee = 1'b0; ew = '0; ea = '0; edat = '0;
      if (c == 9) begin
        ed = 1'b1;
      end else if (c % 2 == 1) begin
        eb = 1'b1; ee = 1'b1; ea = rd_a[(c-1)/2];
      end else begin
        eb = 1'b1; ee = 1'b1; ew = '1; ea = wr_a[c/2-1]; edat = data[c/2-1];
      end
      vectors++;
      if ({busy, done, mem_en, mem_wbe, mem_addr, mem_d} !== {eb, ed, ee, ew, ea, edat}) begin
        miscompares++;
        $display("[TB] FAIL copy c%0d: got busy=%b done=%b en=%b wbe=%h addr=%h d=%h, want busy=%b done=%b en=%b wbe=%h addr=%h d=%h",
                 c, busy, done, mem_en, mem_wbe, mem_addr, mem_d, eb, ed, ee, ew, ea, edat);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ram[wr_a[i]] !== data[i]) begin
        miscompares++;
        $display("[TB] FAIL copy_ram[%h]: got %h want %h", wr_a[i], ram[wr_a[i]], data[i]);
      end
    end
  endtask

  task automatic test_overlap();
    logic [AWIDTH-1:0] rd_a [4] = '{14'h023, 14'h022, 14'h021, 14'h020};
    logic [AWIDTH-1:0] wr_a [4] = '{14'h025, 14'h024, 14'h023, 14'h022};
    logic [DWIDTH-1:0] wd   [4] = '{32'd4, 32'd3, 32'd2, 32'd1};
    logic eb, ed, ee;
    logic [BW-1:0] ew;
    logic [AWIDTH-1:0] ea;
    logic [DWIDTH-1:0] edat;
    for (int i = 0; i < 4; i++) poke(14'h020 + 14'(i), DWIDTH'(i + 1));
    poke(14'h024, '0);
    poke(14'h025, '0);
    drive_start(MODE_COPY, 14'h020, 14'h022, 15'd4, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      eb = 1'b0; ed = 1'b0; ee = 1'b0; ew = '0; ea = '0; edat = '0;
      if (c == 9) begin
        ed = 1'b1;
      end else if (c % 2 == 1) begin
        eb = 1'b1; ee = 1'b1; ea = rd_a[(c-1)/2];
      end else begin
        eb = 1'b1; ee = 1'b1; ew = '1; ea = wr_a[c/2-1]; edat = wd[c/2-1];
      end
      vectors++;
      if ({busy, done, mem_en, mem_wbe, mem_addr, mem_d} !== {eb, ed, ee, ew, ea, edat}) begin
        miscompares++;
        $display("[TB] FAIL overlap c%0d: got busy=%b done=%b en=%b wbe=%h addr=%h d=%h, want busy=%b done=%b en=%b wbe=%h addr=%h d=%h",
                 c, busy, done, mem_en, mem_wbe, mem_addr, mem_d, eb, ed, ee, ew, ea, edat);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ram[14'h022 + 14'(i)] !== DWIDTH'(i + 1)) begin
        miscompares++;
        $display("[TB] FAIL overlap_ram[%h]: got %h want %h", 14'h022 + 14'(i),
                 ram[14'h022 + 14'(i)], DWIDTH'(i + 1));
      end
    end
  endtask

  task automatic test_fill_wrap();
    logic [AWIDTH-1:0] wr_a [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    logic eb, ed, ee;
    logic [BW-1:0] ew;
    logic [AWIDTH-1:0] ea;
    logic [DWIDTH-1:0] edat;
    for (int i = 0; i < 4; i++) poke(wr_a[i], '0);
    drive_start(MODE_FILL, 14'h1234, 14'h3FFE, 15'd4, 32'hDEADBEEF);
    for (int c = 1; c <= 5; c++) begin
      eb = 1'b0; ed = 1'b0; ee = 1'b0; ew = '0; ea = '0; edat = '0;
      if (c == 5) begin
        ed = 1'b1;
      end else begin
        eb = 1'b1; ee = 1'b1; ew = '1; ea = wr_a[c-1]; edat = 32'hDEADBEEF;
      end
      vectors++;
      if ({busy, done, mem_en, mem_wbe, mem_addr, mem_d} !== {eb, ed, ee, ew, ea, edat}) begin
        miscompares++;
        $display("[TB] FAIL fill c%0d: got busy=%b done=%b en=%b wbe=%h addr=%h d=%h, want busy=%b done=%b en=%b wbe=%h addr=%h d=%h",
                 c, busy, done, mem_en, mem_wbe, mem_addr, mem_d, eb, ed, ee, ew, ea, edat);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ram[wr_a[i]] !== 32'hDEADBEEF) begin
        miscompares++;
        $display("[TB] FAIL fill_ram[%h]: got %h want deadbeef", wr_a[i], ram[wr_a[i]]);
      end
    end
  endtask

  task automatic test_len_zero();
    drive_start(MODE_COPY, 14'h000, 14'h010, 15'd0, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      vectors++;
      if ({busy, done, mem_en, mem_wbe, mem_addr, mem_d} !== {1'b0, (c == 1), 1'b0, {BW{1'b0}}, {AWIDTH{1'b0}}, {DWIDTH{1'b0}}}) begin
        miscompares++;
        $display("[TB] FAIL len0 c%0d: got busy=%b done=%b en=%b wbe=%h addr=%h d=%h, want busy=0 done=%b rest 0",
                 c, busy, done, mem_en, mem_wbe, mem_addr, mem_d, (c == 1));
      end
      tick();
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) poke(14'h040 + 14'(i), 32'h5500 + DWIDTH'(i));
    poke(14'h080, '0);
    poke(14'h081, '0);
    drive_start(MODE_COPY, 14'h040, 14'h080, 15'd8, 32'h0);
    // cycles 1..3: read 0x40, write 0x80, read 0x41
    vectors++;
    if ({mem_en, mem_wbe, mem_addr} !== {1'b1, 4'h0, 14'h040}) begin
      miscompares++;
      $display("[TB] FAIL abort_c1: got en=%b wbe=%h addr=%h, want en=1 wbe=0 addr=040", mem_en, mem_wbe, mem_addr);
    end
    tick();
    vectors++;
    if ({mem_en, mem_wbe, mem_addr, mem_d} !== {1'b1, 4'hF, 14'h080, 32'h5500}) begin
      miscompares++;
      $display("[TB] FAIL abort_c2: got en=%b wbe=%h addr=%h d=%h, want en=1 wbe=f addr=080 d=5500", mem_en, mem_wbe, mem_addr, mem_d);
    end
    tick();
    tick();
    abort = 1'b1;
    #1;
    vectors++;
    if ({busy, done, mem_en, mem_wbe, mem_addr, mem_d} !== {1'b1, 1'b0, 1'b0, {BW{1'b0}}, {AWIDTH{1'b0}}, {DWIDTH{1'b0}}}) begin
      miscompares++;
      $display("[TB] FAIL abort_c4: got busy=%b done=%b en=%b wbe=%h addr=%h d=%h, want busy=1 rest 0",
               busy, done, mem_en, mem_wbe, mem_addr, mem_d);
    end
    tick();
    abort = 1'b0;
    for (int c = 5; c <= 7; c++) begin
      vectors++;
      if ({busy, done, mem_en} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL abort_idle c%0d: got busy=%b done=%b en=%b, want 0 0 0", c, busy, done, mem_en);
      end
      tick();
    end
    vectors++;
    if ({ram[14'h080], ram[14'h081]} !== {32'h5500, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL abort_ram: got %h %h want 00005500 00000000", ram[14'h080], ram[14'h081]);
    end
  endtask

  task automatic test_reset_midfill();
    poke(14'h300, '0);
    drive_start(MODE_FILL, 14'h000, 14'h200, 15'd6, 32'h12345678);
    vectors++;
    if ({busy, mem_en, mem_addr, mem_d} !== {1'b1, 1'b1, 14'h200, 32'h12345678}) begin
      miscompares++;
      $display("[TB] FAIL rstfill_c1: got busy=%b en=%b addr=%h d=%h, want 1 1 200 12345678", busy, mem_en, mem_addr, mem_d);
    end
    tick();
    start = 1'b1; mode = MODE_COPY; src_addr = 14'h010; dst_addr = 14'h300; len = 15'd2;
    #1;
    vectors++;
    if ({busy, mem_en, mem_addr, mem_d} !== {1'b1, 1'b1, 14'h201, 32'h12345678}) begin
      miscompares++;
      $display("[TB] FAIL rstfill_c2: got busy=%b en=%b addr=%h d=%h, want 1 1 201 12345678", busy, mem_en, mem_addr, mem_d);
    end
    tick();
    start = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, mem_en, mem_wbe, mem_addr, mem_d} !== {1'b1, 1'b1, 4'hF, 14'h202, 32'h12345678}) begin
      miscompares++;
      $display("[TB] FAIL rstfill_c3: got busy=%b en=%b wbe=%h addr=%h d=%h, want 1 1 f 202 12345678", busy, mem_en, mem_wbe, mem_addr, mem_d);
    end
    tick();
    rst = 1'b0;
    for (int c = 4; c <= 5; c++) begin
      vectors++;
      if ({busy, done, mem_en, mem_wbe, mem_addr, mem_d} !== '0) begin
        miscompares++;
        $display("[TB] FAIL rstfill_after c%0d: got busy=%b done=%b en=%b wbe=%h addr=%h d=%h, want all 0",
                 c, busy, done, mem_en, mem_wbe, mem_addr, mem_d);
      end
      tick();
    end
    vectors++;
    if (ram[14'h300] !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL rstfill_ram300: got %h want 00000000", ram[14'h300]);
    end
  endtask

  task automatic test_back_to_back();
    drive_start(MODE_FILL, 14'h000, 14'h400, 15'd1, 32'h11111111);
    vectors++;
    if ({busy, mem_en, mem_addr, mem_d} !== {1'b1, 1'b1, 14'h400, 32'h11111111}) begin
      miscompares++;
      $display("[TB] FAIL b2b_c1: got busy=%b en=%b addr=%h d=%h, want 1 1 400 11111111", busy, mem_en, mem_addr, mem_d);
    end
    tick();
    // start raised during the done cycle must not be taken until IDLE
    start = 1'b1; mode = MODE_FILL; dst_addr = 14'h410; len = 15'd1; fill_value = 32'h22222222;
    #1;
    vectors++;
    if ({busy, done, mem_en} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL b2b_c2: got busy=%b done=%b en=%b, want 0 1 0", busy, done, mem_en);
    end
    tick();
    vectors++;
    if ({busy, done, mem_en} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL b2b_c3: got busy=%b done=%b en=%b, want 0 0 0", busy, done, mem_en);
    end
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, mem_en, mem_addr, mem_d} !== {1'b1, 1'b1, 14'h410, 32'h22222222}) begin
      miscompares++;
      $display("[TB] FAIL b2b_c4: got busy=%b en=%b addr=%h d=%h, want 1 1 410 22222222", busy, mem_en, mem_addr, mem_d);
    end
    tick();
    vectors++;
    if ({busy, done, mem_en} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL b2b_c5: got busy=%b done=%b en=%b, want 0 1 0", busy, done, mem_en);
    end
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_copy();
    test_overlap();
    test_fill_wrap();
    test_len_zero();
    test_abort();
    test_reset_midfill();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
